// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped, write-back, write-allocate cache between a CPU word port and MainMemory
module cache_controller #(
  parameter int NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [8:0]   cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_ready,
  output logic         busy,
  output logic         mem_read,
  output logic         mem_write,
  output logic [4:0]   mem_address,
  output logic [511:0] mem_wdata,
  input  logic [511:0] mem_rdata
);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 5 - INDEX_W;
  localparam int TAG_WS  = (TAG_W > 0) ? TAG_W : 1;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FETCH, FILL} state_t;

  state_t               state_q, state_d;
  logic                 req_we_q, req_we_d;
  logic [8:0]           req_addr_q, req_addr_d;
  logic [31:0]          req_wdata_q, req_wdata_d;
  logic [NUM_LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_WS-1:0]    tag_q [NUM_LINES];
  logic [511:0]         data_q [NUM_LINES];

  logic [31:0]  cpu_rdata_q, cpu_rdata_d;
  logic         cpu_ready_q, cpu_ready_d;
  logic         busy_q, busy_d;
  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic [4:0]   mem_address_q, mem_address_d;
  logic [511:0] mem_wdata_q, mem_wdata_d;

  logic               line_we, tag_we;
  logic [511:0]       line_wdata;
  logic [INDEX_W-1:0] idx;
  logic [4:0]         req_block, victim_block;
  logic [TAG_WS-1:0]  req_tag;
  logic [3:0]         off;
  logic [511:0]       line;
  logic               hit;

  // Everything below derives from the latched request, never from cpu_* directly.
  assign idx          = req_addr_q[4 +: INDEX_W];
  assign req_block    = req_addr_q[8:4];
  assign req_tag      = TAG_WS'(req_block >> INDEX_W);
  assign off          = req_addr_q[3:0];
  assign line         = data_q[idx];
  assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
  assign victim_block = 5'((32'(tag_q[idx]) << INDEX_W) | 32'(idx));

  always_comb begin
    state_d       = state_q;
    req_we_d      = req_we_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_ready_d   = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    line_we       = 1'b0;
    tag_we        = 1'b0;
    line_wdata    = line;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          if (req_we_q) begin
            line_we                   = 1'b1;
            line_wdata[32*off +: 32]  = req_wdata_q;
            dirty_d[idx]              = 1'b1;
          end else begin
            cpu_rdata_d = line[32*off +: 32];
          end
          cpu_ready_d = 1'b1;
          state_d     = IDLE;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          mem_write_d   = 1'b1;
          mem_address_d = victim_block;
          mem_wdata_d   = line;
          state_d       = WRITEBACK;
        end else begin
          mem_read_d    = 1'b1;
          mem_address_d = req_block;
          state_d       = FETCH;
        end
      end
      WRITEBACK: begin
        mem_read_d    = 1'b1;
        mem_address_d = req_block;
        state_d       = FETCH;
      end
      FETCH: state_d = FILL;
      FILL: begin
        line_we      = 1'b1;
        line_wdata   = mem_rdata;
        tag_we       = 1'b1;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d      = COMPARE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_we_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      valid_q       <= '0;
      dirty_q       <= '0;
      cpu_rdata_q   <= '0;
      cpu_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      req_we_q      <= req_we_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_ready_q   <= cpu_ready_d;
      busy_q        <= busy_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      if (line_we) data_q[idx] <= line_wdata;
      if (tag_we)  tag_q[idx]  <= req_tag;
    end
  end

  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_ready   = cpu_ready_q;
  assign busy        = busy_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized self-checking bench with a behavioural cache and memory model
module tb_cache_controller;
  localparam int NL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, cpu_req, cpu_we;
  logic [8:0]   cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_ready, busy, mem_read, mem_write;
  logic [4:0]   mem_address;
  logic [511:0] mem_wdata;
  logic [511:0] mem_rdata = '0;

  cache_controller #(.NUM_LINES(NL)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // MainMemory: write commits on negedge, read sampled at posedge, data a little later
  logic [31:0]  mem_arr [32][16];
  bit           rd_pend = 0;
  logic [4:0]   rd_addr;
  int           mon_ev[$];
  logic [511:0] mon_data[$];

  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      for (int w = 0; w < 16; w++) mem_arr[mem_address][w] = mem_wdata[32*w +: 32];
      mon_ev.push_back(32 + int'(mem_address));
      mon_data.push_back(mem_wdata);
    end
    if (mem_read === 1'b1) begin
      rd_pend = 1;
      rd_addr = mem_address;
      mon_ev.push_back(int'(mem_address));
      mon_data.push_back('0);
    end
  end

  always @(posedge clk) begin
    if (rd_pend) begin
      rd_pend = 0;
      #1;
      for (int w = 0; w < 16; w++) mem_rdata[32*w +: 32] = mem_arr[rd_addr][w];
    end
  end

  // Reference model
  bit           ref_v [NL];
  bit           ref_d [NL];
  int           ref_t [NL];
  logic [31:0]  ref_line [NL][16];
  logic [31:0]  ref_mem [32][16];
  logic [31:0]  last_rd;
  int           exp_ev[$];
  logic [511:0] exp_data[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < NL; i++) begin
      ref_v[i] = 0;
      ref_d[i] = 0;
    end
    last_rd = '0;
  endtask

  task automatic predict(input bit we, input logic [8:0] a, input logic [31:0] wd, output int lat);
    int blk, idx, tg, off, vb;
    logic [511:0] bd;
    blk = int'(a[8:4]);
    idx = blk % NL;
    tg  = blk / NL;
    off = int'(a[3:0]);
    lat = 1;
    if (!(ref_v[idx] && ref_t[idx] == tg)) begin
      lat = 4;
      if (ref_v[idx] && ref_d[idx]) begin
        vb = ref_t[idx] * NL + idx;
        for (int w = 0; w < 16; w++) begin
          bd[32*w +: 32] = ref_line[idx][w];
          ref_mem[vb][w] = ref_line[idx][w];
        end
        exp_ev.push_back(32 + vb);
        exp_data.push_back(bd);
        lat = 5;
      end
      exp_ev.push_back(blk);
      exp_data.push_back('0);
      for (int w = 0; w < 16; w++) ref_line[idx][w] = ref_mem[blk][w];
      ref_v[idx] = 1;
      ref_d[idx] = 0;
      ref_t[idx] = tg;
    end
    if (we) begin
      ref_line[idx][off] = wd;
      ref_d[idx] = 1;
    end else begin
      last_rd = ref_line[idx][off];
    end
  endtask

  task automatic check_traffic();
    int e, m;
    logic [511:0] ed, md;
    while (exp_ev.size() > 0) begin
      e  = exp_ev.pop_front();
      ed = exp_data.pop_front();
      if (mon_ev.size() == 0) begin
        check("mem_event_missing", 32'hFFFF_FFFF, e);
      end else begin
        m  = mon_ev.pop_front();
        md = mon_data.pop_front();
        check("mem_event", m, e);
        if (e >= 32)
          for (int w = 0; w < 16; w++) check("wb_word", md[32*w +: 32], ed[32*w +: 32]);
      end
    end
    check("extra_mem_events", mon_ev.size(), 0);
    mon_ev.delete();
    mon_data.delete();
  endtask

  // Called at a negedge; returns at the negedge of the cpu_ready cycle
  task automatic run_req(input bit we, input logic [8:0] a, input logic [31:0] wd, output time t_ready);
    int  lat, k;
    bit  seen;
    predict(we, a, wd, lat);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 0; cpu_we = 1'($urandom); cpu_addr = 9'($urandom); cpu_wdata = $urandom;
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    check("ready_pulse_width", cpu_ready, 0);
    k = 0;
    seen = 0;
    while (!seen && k < 12) begin
      @(posedge clk); @(negedge clk);
      k++;
      if (cpu_ready === 1'b1) seen = 1;
      else check("busy_wait", busy, 1);
    end
    t_ready = $time;
    check("latency", k, lat);
    check("busy_in_ready", busy, 0);
    check("cpu_rdata", cpu_rdata, last_rd);
    check_traffic();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    time t0, t1, tp;
    logic [8:0] a;
    int lat;
    int b2b [4];

    for (int b = 0; b < 32; b++)
      for (int w = 0; w < 16; w++) begin
        mem_arr[b][w] = 32'(b * 16 + w);
        ref_mem[b][w] = 32'(b * 16 + w);
      end

    rst = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005; cpu_wdata = '0;
    @(posedge clk); @(negedge clk);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", 32'(|mem_wdata), 0);
    @(posedge clk); @(negedge clk);
    check("rst_priority_busy", busy, 0);
    rst = 0; cpu_req = 0;
    ref_reset();
    mon_ev.delete(); mon_data.delete();

    run_req(0, 9'h005, 0, tp);
    check("clean_miss_data", cpu_rdata, 32'h5);
    run_req(0, 9'h00A, 0, tp);
    check("read_hit_data", cpu_rdata, 32'h0A);
    run_req(1, 9'h003, 32'hDEADBEEF, tp);
    run_req(0, 9'h103, 0, tp);
    check("evict_data", cpu_rdata, 32'h103);
    check("evict_mem_word3", mem_arr[0][3], 32'hDEADBEEF);

    run_req(1, 9'h1F0, 32'h12345678, tp);
    run_req(0, 9'h1F0, 0, tp);
    check("alloc_store_data", cpu_rdata, 32'h12345678);
    run_req(0, 9'h1F1, 0, tp);
    check("alloc_neighbour", cpu_rdata, 32'h1F1);

    b2b[0] = 9'h1F2; b2b[1] = 9'h100; b2b[2] = 9'h1F3; b2b[3] = 9'h10F;
    run_req(0, 9'(b2b[0]), 0, t0);
    for (int i = 1; i < 4; i++) begin
      run_req(0, 9'(b2b[i]), 0, t1);
      check("b2b_gap", 32'(t1 - t0), 32'd20);
      t0 = t1;
    end

    // Dirty block 31 sits in line 7; block 15 evicts it, reset lands during FETCH
    predict(0, 9'h0F5, 0, lat);
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h0F5;
    @(posedge clk); #1; cpu_req = 0;
    @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("abort_wb_cycle", mem_write, 1);
    @(posedge clk); @(negedge clk);
    check("abort_fetch_cycle", mem_read, 1);
    rst = 1;
    @(posedge clk); @(negedge clk);
    check("abort_mem_read", mem_read, 0);
    check("abort_mem_write", mem_write, 0);
    check("abort_cpu_ready", cpu_ready, 0);
    check("abort_busy", busy, 0);
    rst = 0;
    ref_reset();
    check_traffic();
    run_req(0, 9'h0F5, 0, tp);
    check("post_abort_data", cpu_rdata, 32'h0F5);
    run_req(0, 9'h1F0, 0, tp);
    check("wb_before_abort", cpu_rdata, 32'h12345678);

    for (int n = 0; n < 80; n++) begin
      a = {5'(($urandom_range(0, 3) << 3) | $urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      run_req(1'($urandom), a, $urandom, tp);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); @(negedge clk);
        check("idle_busy", busy, 0);
      end
    end

    for (int b = 0; b < 32; b++)
      for (int w = 0; w < 16; w++) check("mem_final", mem_arr[b][w], ref_mem[b][w]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
